burst_memory: RTL and testbench

// - Parametrised byte-addressable, big-endian memory model for the MIPS processor datapath.
// - Serves single-word and burst (4/8/16-word) reads and writes, one word per cycle.
// - Holds the program/data image based at START_ADDR; sits behind fetch and load/store stages.
// - Successor to the single-port word memory: adds burst writes, registered beat sequencing,

---
 rtl/burst_memory_if.sv | 35 +++
 rtl/burst_memory.sv | 144 ++++++++++++++
 tb/tb_burst_memory.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/burst_memory_if.sv
// Request/response bundle for burst_memory. addr_err exists only when MEM_RANGE_CHECK_EN is defined.
interface burst_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [1:0]            access_size;
  logic                  rw;
  logic                  enable;
  logic                  busy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
`ifdef MEM_RANGE_CHECK_EN
  logic                  addr_err;

  modport master (
    output address, data_in, access_size, rw, enable,
    input  busy, data_out, data_valid, addr_err
  );
  modport slave (
    input  address, data_in, access_size, rw, enable,
    output busy, data_out, data_valid, addr_err
  );
`else
  modport master (
    output address, data_in, access_size, rw, enable,
    input  busy, data_out, data_valid
  );
  modport slave (
    input  address, data_in, access_size, rw, enable,
    output busy, data_out, data_valid
  );
`endif
endinterface

// File: rtl/burst_memory.sv
// Big-endian byte-addressable burst memory (1/4/8/16 words, one word per cycle).
// Define MEM_RANGE_CHECK_EN to reject out-of-window requests with an addr_err pulse.
module burst_memory #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 1048576,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000
) (
  input  logic          clock,
  input  logic          reset,
  burst_memory_if.slave bus
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(DEPTH - 1) & ~ADDR_WIDTH'(BPW - 1);
  localparam logic [OFF_W-1:0]      BPW_OFF  = OFF_W'(BPW);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RBURST = 2'd1;
  localparam logic [1:0] WBURST = 2'd2;

  logic [7:0]            mem [DEPTH];
  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [3:0]            last;
  logic [OFF_W-1:0]      cur_off;
  logic [ADDR_WIDTH-1:0] addr_diff;
  logic [OFF_W-1:0]      off0;
  logic                  in_range;
  logic                  accept;
  logic                  beat_go;
  logic                  beat_rd;
  logic [OFF_W-1:0]      beat_off;
  logic [DATA_WIDTH-1:0] rd_word;

  function automatic logic [3:0] burst_last(input logic [1:0] size);
    case (size)
      2'b00:   burst_last = 4'd0;
      2'b01:   burst_last = 4'd3;
      2'b10:   burst_last = 4'd7;
      default: burst_last = 4'd15;
    endcase
  endfunction

  assign addr_diff = bus.address - START_ADDR;
  assign off0      = OFF_W'(addr_diff & OFF_MASK);

`ifdef MEM_RANGE_CHECK_EN
  assign in_range = (bus.address >= START_ADDR) &&
                    ({1'b0, addr_diff} < (ADDR_WIDTH + 1)'(DEPTH));
`else
  assign in_range = 1'b1;
`endif

  assign accept = (state == IDLE) && bus.enable && in_range;

  // Beat 0 runs on the accept edge from the live address; later beats use the running offset.
  always_comb begin
    beat_go  = 1'b0;
    beat_rd  = 1'b0;
    beat_off = off0;
    case (state)
      IDLE: begin
        beat_go = accept;
        beat_rd = bus.rw;
      end
      RBURST: begin
        beat_go  = 1'b1;
        beat_rd  = 1'b1;
        beat_off = cur_off;
      end
      WBURST: begin
        beat_go  = 1'b1;
        beat_off = cur_off;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BPW; i++)
      rd_word[DATA_WIDTH-1-8*i -: 8] = mem[beat_off + OFF_W'(i)];
  end

  // Storage and beat offset: not reset, so memory survives a reset.
  always_ff @(posedge clock) begin
    if (beat_go && !beat_rd)
      for (int i = 0; i < BPW; i++)
        mem[beat_off + OFF_W'(i)] <= bus.data_in[DATA_WIDTH-1-8*i -: 8];
    cur_off <= beat_off + BPW_OFF;
  end

  // Control and read port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      busy_set(1'b0);
      cnt            <= '0;
      last           <= '0;
      bus.data_valid <= 1'b0;
      bus.data_out   <= '0;
`ifdef MEM_RANGE_CHECK_EN
      bus.addr_err   <= 1'b0;
`endif
    end else begin
      bus.data_valid <= beat_go && beat_rd;
      if (beat_go && beat_rd)
        bus.data_out <= rd_word;
`ifdef MEM_RANGE_CHECK_EN
      bus.addr_err <= (state == IDLE) && bus.enable && !in_range;
`endif
      case (state)
        IDLE: begin
          if (accept && burst_last(bus.access_size) != 4'd0) begin
            last  <= burst_last(bus.access_size);
            cnt   <= 4'd1;
            busy_set(1'b1);
            state <= bus.rw ? RBURST : WBURST;
          end
        end
        RBURST, WBURST: begin
          if (cnt == last) begin
            cnt   <= '0;
            busy_set(1'b0);
            state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          busy_set(1'b0);
          state <= IDLE;
        end
      endcase
    end
  end

  task automatic busy_set(input logic v);
    bus.busy <= v;
  endtask

endmodule

// File: tb/tb_burst_memory.sv
// Scoreboard bench for burst_memory: stimulus pushes expected read beats, a monitor pops them.
module tb_burst_memory;

  logic clk = 1'b0;
  logic rst = 1'b1;

  burst_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  burst_memory dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every read beat must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h, expected no read beat", bus.data_out);
      end else begin
        check("read_beat", bus.data_out, exp_q.pop_front());
      end
    end
  end

  // Issue a request at the current negedge and walk it to the negedge after its last beat.
  task automatic run_burst(input logic r, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] base, input int intrude);
    int n;
    int busy_hi;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 4 : (sz == 2'd2) ? 8 : 16;
    bus.enable      = 1'b1;
    bus.rw          = r;
    bus.address     = a;
    bus.access_size = sz;
    bus.data_in     = base;
    busy_hi         = 0;
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_hi++;
      if (k == intrude) begin
        bus.enable      = 1'b1;
        bus.rw          = 1'b0;
        bus.address     = 32'h80020000;
        bus.access_size = 2'd0;
        bus.data_in     = 32'h55555555;
      end else begin
        bus.enable  = 1'b0;
        bus.rw      = r;
        bus.data_in = base + 32'(k);
      end
    end
    @(negedge clk);
    bus.enable = 1'b0;
    check("busy_cycles", 32'(busy_hi), 32'(n - 1));
    check("busy_end", 32'(bus.busy), 32'd0);
    if (r) check("last_beat_valid", 32'(bus.data_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable      = 1'b0;
    bus.rw          = 1'b1;
    bus.address     = '0;
    bus.access_size = 2'd0;
    bus.data_in     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.data_valid), 32'd0);
    check("reset_data", bus.data_out, 32'd0);
`ifdef MEM_RANGE_CHECK_EN
    check("reset_addr_err", 32'(bus.addr_err), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Single-word write then read, back to back.
    run_burst(1'b0, 32'h80020000, 2'd0, 32'hDEADBEEF, -1);
    check("byte0", 32'(dut.mem[0]), 32'h000000DE);
    check("byte3", 32'(dut.mem[3]), 32'h000000EF);
    exp_q.push_back(32'hDEADBEEF);
    run_burst(1'b1, 32'h80020000, 2'd0, 32'h0, -1);

    // Four-word burst write then read.
    run_burst(1'b0, 32'h80020010, 2'd1, 32'd1, -1);
    for (int k = 1; k <= 4; k++) exp_q.push_back(32'(k));
    run_burst(1'b1, 32'h80020010, 2'd1, 32'h0, -1);

    // Eight-word read with a write attempt during beat 3; next read right after busy falls.
    run_burst(1'b0, 32'h80020000, 2'd2, 32'h000000A0, -1);
    for (int k = 0; k < 8; k++) exp_q.push_back(32'h000000A0 + 32'(k));
    run_burst(1'b1, 32'h80020000, 2'd2, 32'h0, 3);
    exp_q.push_back(32'h000000A0);
    run_burst(1'b1, 32'h80020000, 2'd0, 32'h0, -1);

    // Wrap at the top of memory: DEPTH-8, DEPTH-4, 0, 4.
    run_burst(1'b0, 32'h8011FFF8, 2'd1, 32'h000000C0, -1);
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h000000C0 + 32'(k));
    run_burst(1'b1, 32'h8011FFF8, 2'd1, 32'h0, -1);
    exp_q.push_back(32'h000000C2);
    run_burst(1'b1, 32'h80020000, 2'd0, 32'h0, -1);
    exp_q.push_back(32'h000000C3);
    run_burst(1'b1, 32'h80020004, 2'd0, 32'h0, -1);

    // Reset asserted before beat 5 of a 16-word read.
    exp_q.push_back(32'h000000C2);
    exp_q.push_back(32'h000000C3);
    exp_q.push_back(32'h000000A2);
    exp_q.push_back(32'h000000A3);
    exp_q.push_back(32'h000000A4);
    bus.enable      = 1'b1;
    bus.rw          = 1'b1;
    bus.address     = 32'h80020000;
    bus.access_size = 2'd3;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.enable = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_valid", 32'(bus.data_valid), 32'd0);
    check("midreset_data", bus.data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'h000000C2);
    run_burst(1'b1, 32'h80020000, 2'd0, 32'h0, -1);

    // Address below the window.
    run_burst(1'b0, 32'h80110000, 2'd0, 32'h12345678, -1);
`ifdef MEM_RANGE_CHECK_EN
    bus.enable      = 1'b1;
    bus.rw          = 1'b1;
    bus.address     = 32'h80010000;
    bus.access_size = 2'd0;
    @(negedge clk);
    bus.enable = 1'b0;
    check("range_err", 32'(bus.addr_err), 32'd1);
    check("range_valid", 32'(bus.data_valid), 32'd0);
    check("range_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("range_err_pulse", 32'(bus.addr_err), 32'd0);
    exp_q.push_back(32'h12345678);
    run_burst(1'b1, 32'h80110000, 2'd0, 32'h0, -1);
`else
    exp_q.push_back(32'h12345678);
    run_burst(1'b1, 32'h80010000, 2'd0, 32'h0, -1);
`endif

    repeat (3) @(negedge clk);
    check("pending_reads", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
